shared_mem_banked: RTL

- Multi-bank shared memory between COUNT SIMD processors; successor to the single-bank shared_mem.
- Word-interleaved banks let requests to different banks complete in the same cycle.
- Each bank has its own round-robin arbiter; grants are fair and starvation-free.
- Writes are partial, at 32-bit lane granularity. Reads return one cycle after grant, flagged by a per-port valid.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/shared_mem_banked.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, lane constants and address decode helpers
// Purpose: common definitions for shared_mem_banked and its bank arbiters.
// Contents: addr_t word address, LANE_W lane width, wr_size encodings,
//           bank_of/row_of word-interleaved address decode.
package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int LANE_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  // i_wr_size encodes (number of 32-bit lanes - 1), starting at lane 0
  localparam logic [1:0] SZ_32  = 2'd0;
  localparam logic [1:0] SZ_64  = 2'd1;
  localparam logic [1:0] SZ_96  = 2'd2;
  localparam logic [1:0] SZ_128 = 2'd3;

  // banks is a power of two, so masking with banks-1 picks the low bits
  // (and yields 0 when banks == 1)
  function automatic int unsigned bank_of(addr_t addr, int unsigned banks);
    int unsigned a;
    a = 32'(addr);
    return a & (banks - 1);
  endfunction

  // rows beyond depth wrap silently
  function automatic int unsigned row_of(addr_t addr, int unsigned banks, int unsigned depth);
    int unsigned a;
    a = 32'(addr);
    return (a / banks) % depth;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one per memory bank
// Purpose: grants at most one requester per cycle, searching from ptr.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset; forces grant to 0, ptr to 0
//   i_req   [COUNT] request vector
//   o_grant [COUNT] one-hot grant (combinational)
module rr_arbiter #(
  parameter int COUNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [COUNT-1:0] i_req,
  output logic [COUNT-1:0] o_grant
);

  localparam int PW = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;

  always_comb begin : p_arb
    int idx;
    idx      = 0;
    o_grant  = '0;
    ptr_next = ptr;
    if (!i_rst) begin
      // walk from farthest to nearest so the requester closest to ptr wins
      for (int k = COUNT - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % COUNT;
        if (i_req[idx]) begin
          o_grant      = '0;
          o_grant[idx] = 1'b1;
          ptr_next     = PW'((idx + 1) % COUNT);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/shared_mem_banked.sv
// rtl/shared_mem_banked.sv - word-interleaved multi-bank shared memory for COUNT ports
// Purpose: BANKS single-port RAMs, each with its own round-robin arbiter, so
//          requests to different banks complete in the same cycle.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req_rd, i_req_wr       [COUNT] requests, held until granted (write wins)
//   i_proc_wr, i_wr_size     [COUNT] write data and lane count minus 1
//   i_proc_addr              [COUNT] word address
//   o_grant_rd, o_grant_wr   [COUNT] combinational grants
//   o_proc_rd, o_rd_valid    [COUNT] read data/valid, one cycle after read grant
module shared_mem_banked
  import mem_pkg::*;
#(
  parameter int COUNT    = 4,
  parameter int BUS_SIZE = 128,
  parameter int BANKS    = 2,
  parameter int DEPTH    = 512
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [COUNT-1:0]                 i_req_rd,
  input  logic [COUNT-1:0]                 i_req_wr,
  input  logic [COUNT-1:0][BUS_SIZE-1:0]   i_proc_wr,
  input  logic [COUNT-1:0][1:0]            i_wr_size,
  input  addr_t [COUNT-1:0]                i_proc_addr,
  output logic [COUNT-1:0]                 o_grant_rd,
  output logic [COUNT-1:0]                 o_grant_wr,
  output logic [COUNT-1:0][BUS_SIZE-1:0]   o_proc_rd,
  output logic [COUNT-1:0]                 o_rd_valid
);

  localparam int LANES = BUS_SIZE / LANE_W;
  localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [COUNT-1:0]    eff_rd;
  logic [COUNT-1:0]    eff_wr;
  logic [BW-1:0]       port_bank [COUNT];
  logic [RW-1:0]       port_row  [COUNT];
  logic [COUNT-1:0]    bank_req  [BANKS];
  logic [COUNT-1:0]    bank_gnt  [BANKS];
  logic [BUS_SIZE-1:0] bank_rd   [BANKS];
  logic [COUNT-1:0]    port_gnt;

  logic [COUNT-1:0]               rd_valid_q;
  logic [BW-1:0]                  rd_bank_q [COUNT];
  logic [COUNT-1:0][BUS_SIZE-1:0] hold_q;

  // A port requesting both read and write issues the write; the read stays
  // pending because the processor keeps i_req_rd asserted.
  always_comb begin
    eff_wr = i_req_wr;
    eff_rd = i_req_rd & ~i_req_wr;
    for (int p = 0; p < COUNT; p++) begin
      port_bank[p] = BW'(bank_of(i_proc_addr[p], BANKS));
      port_row[p]  = RW'(row_of(i_proc_addr[p], BANKS, DEPTH));
    end
    for (int b = 0; b < BANKS; b++) begin
      bank_req[b] = '0;
      for (int p = 0; p < COUNT; p++) begin
        bank_req[b][p] = (eff_rd[p] | eff_wr[p]) && (int'(port_bank[p]) == b);
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [BUS_SIZE-1:0] mem [DEPTH];
    logic [BUS_SIZE-1:0] rd_q;
    logic                sel_wr;
    logic                sel_rd;
    logic [RW-1:0]       sel_row;
    logic [BUS_SIZE-1:0] sel_data;
    logic [1:0]          sel_size;

    rr_arbiter #(.COUNT(COUNT)) u_arb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_req   (bank_req[b]),
      .o_grant (bank_gnt[b])
    );

    // grant is one-hot, so this selects the single winning port
    always_comb begin
      sel_wr   = 1'b0;
      sel_rd   = 1'b0;
      sel_row  = '0;
      sel_data = '0;
      sel_size = '0;
      for (int p = 0; p < COUNT; p++) begin
        if (bank_gnt[b][p]) begin
          sel_wr   = eff_wr[p];
          sel_rd   = eff_rd[p];
          sel_row  = port_row[p];
          sel_data = i_proc_wr[p];
          sel_size = i_wr_size[p];
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (sel_wr) begin
        for (int l = 0; l < LANES; l++) begin
          if (l <= int'(sel_size)) begin
            mem[sel_row][l*LANE_W +: LANE_W] <= sel_data[l*LANE_W +: LANE_W];
          end
        end
      end
      if (sel_rd) begin
        rd_q <= mem[sel_row];
      end
    end

    assign bank_rd[b] = rd_q;
  end

  always_comb begin
    port_gnt = '0;
    for (int b = 0; b < BANKS; b++) begin
      port_gnt = port_gnt | bank_gnt[b];
    end
    o_grant_wr = port_gnt & eff_wr;
    o_grant_rd = port_gnt & eff_rd;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_valid_q <= '0;
      hold_q     <= '0;
    end else begin
      rd_valid_q <= o_grant_rd;
      for (int p = 0; p < COUNT; p++) begin
        if (rd_valid_q[p]) begin
          hold_q[p] <= o_proc_rd[p];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int p = 0; p < COUNT; p++) begin
      if (o_grant_rd[p]) begin
        rd_bank_q[p] <= port_bank[p];
      end
    end
  end

  // Reset masks a valid that was launched by a grant just before reset rose.
  // Data comes straight from the bank read register in the valid cycle and
  // from the per-port hold register otherwise.
  always_comb begin
    o_rd_valid = rd_valid_q & {COUNT{~i_rst}};
    for (int p = 0; p < COUNT; p++) begin
      o_proc_rd[p] = o_rd_valid[p] ? bank_rd[rd_bank_q[p]] : hold_q[p];
    end
  end

endmodule
